// File: rtl/registerfile_multi.sv
// registerfile_multi: DEPTH x WIDTH register file with one synchronous write
// port, two registered read ports, per-register "written" flags and a
// sequenced clear-all (one register per cycle, DEPTH busy cycles).
//
// Optional build macro: REGFILE_BYPASS_EN
//   undefined (default) : a same-cycle read and write to one address returns
//                         the old contents and old flag (read-before-write)
//   defined             : the read port returns wdata and rinit=1 for that
//                         case (write-first forwarding, independent per port)
// Port list and read latency are identical in both builds.
module registerfile_multi #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              set,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic              rinit0,
  output logic              rinit1,
  output logic              rvalid,
  input  logic              clr,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // True when an index names a physically present register; DEPTH need not
  // be a power of two, so the top of the address space may be unpopulated.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_s;
  logic                busy_r;

  logic [WIDTH-1:0]    regs_r  [DEPTH];
  logic                flags_r [DEPTH];

  logic [WIDTH-1:0]    rdata0_r;
  logic [WIDTH-1:0]    rdata1_r;
  logic                rinit0_r;
  logic                rinit1_r;
  logic                rvalid_r;

  logic                idle_s;
  logic                clear_s;
  logic                last_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic [WIDTH-1:0]    rd0_s;
  logic [WIDTH-1:0]    rd1_s;
  logic                ri0_s;
  logic                ri1_s;

  // Qualify requests: clr wins over we/re in IDLE, everything is ignored
  // while the clear sequence runs.
  always_comb begin
    idle_s   = (state_r == ST_IDLE);
    clear_s  = (state_r == ST_CLEAR);
    last_s   = (cnt_r == ADDR_W'(DEPTH - 1));
    wr_acc_s = idle_s && !clr && we && addr_ok(waddr);
    rd_acc_s = idle_s && !clr && re;
  end

  // Next-state and clear-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {ADDR_W{1'b0}};
        if (clr) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (last_s) begin
          state_s = ST_IDLE;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = ST_CLEAR;
          cnt_s   = cnt_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Read multiplexers; unpopulated addresses fall through to zero data and
  // a clear flag because the loop never matches them.
  always_comb begin
    rd0_s = {WIDTH{1'b0}};
    rd1_s = {WIDTH{1'b0}};
    ri0_s = 1'b0;
    ri1_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd0_s = (raddr0 == ADDR_W'(i)) ? regs_r[i]  : rd0_s;
      ri0_s = (raddr0 == ADDR_W'(i)) ? flags_r[i] : ri0_s;
      rd1_s = (raddr1 == ADDR_W'(i)) ? regs_r[i]  : rd1_s;
      ri1_s = (raddr1 == ADDR_W'(i)) ? flags_r[i] : ri1_s;
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the accepted write to any port reading the same register.
    if (wr_acc_s && (waddr == raddr0)) begin
      rd0_s = wdata;
      ri0_s = 1'b1;
    end else begin
      rd0_s = rd0_s;
      ri0_s = ri0_s;
    end
    if (wr_acc_s && (waddr == raddr1)) begin
      rd1_s = wdata;
      ri1_s = 1'b1;
    end else begin
      rd1_s = rd1_s;
      ri1_s = ri1_s;
    end
`endif
  end

  // FSM state, clear counter and busy flag; busy mirrors the CLEAR state so
  // it is high for exactly DEPTH cycles.
  always_ff @(posedge set) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  // Register array and written flags: clear step or accepted write.
  always_ff @(posedge set) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        regs_r[i]  <= {WIDTH{1'b0}};
        flags_r[i] <= 1'b0;
      end else if (clear_s && (cnt_r == ADDR_W'(i))) begin
        regs_r[i]  <= {WIDTH{1'b0}};
        flags_r[i] <= 1'b0;
      end else if (wr_acc_s && (waddr == ADDR_W'(i))) begin
        regs_r[i]  <= wdata;
        flags_r[i] <= 1'b1;
      end else begin
        regs_r[i]  <= regs_r[i];
        flags_r[i] <= flags_r[i];
      end
    end
  end

  // Registered read ports: load on an accepted read, otherwise hold.
  always_ff @(posedge set) begin
    if (reset) begin
      rdata0_r <= {WIDTH{1'b0}};
      rdata1_r <= {WIDTH{1'b0}};
      rinit0_r <= 1'b0;
      rinit1_r <= 1'b0;
      rvalid_r <= 1'b0;
    end else if (rd_acc_s) begin
      rdata0_r <= rd0_s;
      rdata1_r <= rd1_s;
      rinit0_r <= ri0_s;
      rinit1_r <= ri1_s;
      rvalid_r <= 1'b1;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign rdata0 = rdata0_r;
  assign rdata1 = rdata1_r;
  assign rinit0 = rinit0_r;
  assign rinit1 = rinit1_r;
  assign rvalid = rvalid_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_registerfile_multi.sv
// Scoreboard bench for registerfile_multi: the stimulus pushes the expected
// read result into a queue, a monitor pops and compares on every rvalid.
// Instance a uses the default shape (DEPTH=4), instance b uses DEPTH=3.
module tb_registerfile_multi;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       i0;
    logic       i1;
    string      name;
  } exp_t;

  logic       set;
  logic       reset;
  logic       we_a, re_a, clr_a, we_b, re_b, clr_b;
  logic [1:0] waddr_a, raddr0_a, raddr1_a, waddr_b, raddr0_b, raddr1_b;
  logic [7:0] wdata_a, wdata_b;
  logic [7:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic       rinit0_a, rinit1_a, rvalid_a, busy_a;
  logic       rinit0_b, rinit1_b, rvalid_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec;
  int   n_miss;
  int   nbusy;

  registerfile_multi #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut_a (
    .set(set), .reset(reset), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .re(re_a), .raddr0(raddr0_a), .raddr1(raddr1_a),
    .rdata0(rdata0_a), .rdata1(rdata1_a), .rinit0(rinit0_a), .rinit1(rinit1_a),
    .rvalid(rvalid_a), .clr(clr_a), .busy(busy_a)
  );

  registerfile_multi #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) dut_b (
    .set(set), .reset(reset), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .re(re_b), .raddr0(raddr0_b), .raddr1(raddr1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b), .rinit0(rinit0_b), .rinit1(rinit1_b),
    .rvalid(rvalid_b), .clr(clr_b), .busy(busy_b)
  );

  initial begin
    set = 1'b0;
    forever #5 set = ~set;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge set);
    #1;
  endtask

  task automatic wr(input bit b, input logic [1:0] a, input logic [7:0] d);
    if (b) begin we_b = 1'b1; waddr_b = a; wdata_b = d; end
    else   begin we_a = 1'b1; waddr_a = a; wdata_a = d; end
    tick();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic rd(input bit b, input logic [1:0] a0, input logic [1:0] a1,
                    input logic [7:0] e0, input logic [7:0] e1,
                    input logic ei0, input logic ei1, input string nm);
    exp_t e;
    e.d0 = e0; e.d1 = e1; e.i0 = ei0; e.i1 = ei1; e.name = nm;
    if (b) begin re_b = 1'b1; raddr0_b = a0; raddr1_b = a1; qb.push_back(e); end
    else   begin re_a = 1'b1; raddr0_a = a0; raddr1_a = a1; qa.push_back(e); end
    tick();
    re_a = 1'b0;
    re_b = 1'b0;
  endtask

  initial begin
    exp_t e;
    n_vec = 0; n_miss = 0;
    reset = 1'b1;
    we_a = 1'b0; re_a = 1'b0; clr_a = 1'b0; waddr_a = 2'd0; wdata_a = 8'h00;
    raddr0_a = 2'd0; raddr1_a = 2'd0;
    we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0; waddr_b = 2'd0; wdata_b = 8'h00;
    raddr0_b = 2'd0; raddr1_b = 2'd0;

    fork
      forever begin
        @(negedge set);
        if (rvalid_a === 1'b1) begin
          n_vec++;
          if (qa.size() == 0) begin
            n_miss++;
            $display("FAIL a_unexpected_rvalid: got rvalid=1, required no read result");
          end else begin
            e = qa.pop_front();
            if ({rdata0_a, rdata1_a, rinit0_a, rinit1_a} !== {e.d0, e.d1, e.i0, e.i1}) begin
              n_miss++;
              $display("FAIL a_%s: got d0=%h d1=%h i0=%b i1=%b, required d0=%h d1=%h i0=%b i1=%b",
                       e.name, rdata0_a, rdata1_a, rinit0_a, rinit1_a, e.d0, e.d1, e.i0, e.i1);
            end
          end
        end
        if (rvalid_b === 1'b1) begin
          n_vec++;
          if (qb.size() == 0) begin
            n_miss++;
            $display("FAIL b_unexpected_rvalid: got rvalid=1, required no read result");
          end else begin
            e = qb.pop_front();
            if ({rdata0_b, rdata1_b, rinit0_b, rinit1_b} !== {e.d0, e.d1, e.i0, e.i1}) begin
              n_miss++;
              $display("FAIL b_%s: got d0=%h d1=%h i0=%b i1=%b, required d0=%h d1=%h i0=%b i1=%b",
                       e.name, rdata0_b, rdata1_b, rinit0_b, rinit1_b, e.d0, e.d1, e.i0, e.i1);
            end
          end
        end
      end
    join_none

    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    @(negedge set);
    n_vec++;
    if ({rvalid_a, busy_a, rdata0_a, rdata1_a, rinit0_a, rinit1_a} !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_state: got rvalid=%b busy=%b d0=%h d1=%h i0=%b i1=%b, required all zero",
               rvalid_a, busy_a, rdata0_a, rdata1_a, rinit0_a, rinit1_a);
    end

    // 1: read after reset.
    rd(1'b0, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, "read_after_reset");

    // 2: two writes then a two-port read; idle cycles expose a stuck rvalid.
    wr(1'b0, 2'd1, 8'hA5);
    wr(1'b0, 2'd2, 8'h3C);
    rd(1'b0, 2'd1, 2'd2, 8'hA5, 8'h3C, 1'b1, 1'b1, "read_written");
    tick();
    tick();

    // 3: same-cycle read and write of reg 2 (port 1 reads untouched reg 1).
    we_a = 1'b1; waddr_a = 2'd2; wdata_a = 8'h77;
`ifdef REGFILE_BYPASS_EN
    rd(1'b0, 2'd2, 2'd1, 8'h77, 8'hA5, 1'b1, 1'b1, "rw_collision");
`else
    rd(1'b0, 2'd2, 2'd1, 8'h3C, 8'hA5, 1'b1, 1'b1, "rw_collision");
`endif
    rd(1'b0, 2'd2, 2'd2, 8'h77, 8'h77, 1'b1, 1'b1, "read_after_rw");

    // 4: clear-all with a simultaneous write; reads attempted while busy.
    wr(1'b0, 2'd0, 8'h11);
    wr(1'b0, 2'd3, 8'h44);
    clr_a = 1'b1; we_a = 1'b1; waddr_a = 2'd1; wdata_a = 8'hEE;
    tick();
    clr_a = 1'b0; we_a = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge set);
      if (busy_a === 1'b1) nbusy++;
      re_a = busy_a;
    end
    re_a = 1'b0;
    n_vec++;
    if (nbusy != 4) begin
      n_miss++;
      $display("FAIL clear_busy_cycles: got %0d, required 4", nbusy);
    end
    rd(1'b0, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, "after_clear_01");
    rd(1'b0, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, "after_clear_23");

    // 5: reset during the 2nd busy cycle aborts the clear.
    wr(1'b0, 2'd1, 8'h99);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge set);
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid_clear_busy: got %b, required 0", busy_a);
    end
    rd(1'b0, 2'd1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, "reset_mid_clear_regs");
    wr(1'b0, 2'd3, 8'h42);
    rd(1'b0, 2'd3, 2'd1, 8'h42, 8'h00, 1'b1, 1'b0, "write_after_reset");

    // 6: DEPTH=3 instance, write to the unpopulated address 3 is dropped.
    wr(1'b1, 2'd0, 8'h11);
    wr(1'b1, 2'd1, 8'h22);
    wr(1'b1, 2'd2, 8'h33);
    wr(1'b1, 2'd3, 8'hFF);
    rd(1'b1, 2'd3, 2'd0, 8'h00, 8'h11, 1'b0, 1'b1, "oob_read");
    rd(1'b1, 2'd1, 2'd2, 8'h22, 8'h33, 1'b1, 1'b1, "oob_regs_intact");

    tick();
    tick();
    tick();
    n_vec++;
    if (qa.size() != 0) begin
      n_miss++;
      $display("FAIL a_missing_rvalid: got %0d reads unanswered, required 0", qa.size());
    end
    n_vec++;
    if (qb.size() != 0) begin
      n_miss++;
      $display("FAIL b_missing_rvalid: got %0d reads unanswered, required 0", qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
